// File: rtl/apb_pwm_pkg.sv
// Register map, CTRL field positions and per-channel configuration record.
// Shared by the APB front end and the channel generators.
// Pure declarations: no timing, no flow control.
package apb_pwm_pkg;

    localparam int CFG_W = 32;

    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_PULSE  = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_POL    = 1;
    localparam int CTRL_IE     = 2;
    localparam int STATUS_WRAP = 0;

    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] pulse;
        logic             en;
        logic             pol;
        logic             ie;
    } chan_cfg_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM generator: free-running counter, active PERIOD/PULSE, wrap detect, output.
// Latency: output is combinational from the registered counter/active values.
// Backpressure: none; shadows are sampled only at wrap or while disabled.
module pwm_channel
    import apb_pwm_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  chan_cfg_t cfg,
    output logic      wrap_set,
    output logic      pwm
);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] period_act;
    logic [CNT_WIDTH-1:0] pulse_act;
    logic [CNT_WIDTH-1:0] period_sh;
    logic [CNT_WIDTH-1:0] pulse_sh;
    logic                 running;
    logic                 unused_cfg;

    assign period_sh  = cfg.period[CNT_WIDTH-1:0];
    assign pulse_sh   = cfg.pulse[CNT_WIDTH-1:0];
    assign unused_cfg = ^{cfg.ie, cfg.period >> CNT_WIDTH, cfg.pulse >> CNT_WIDTH};

    // A zero period parks the channel: counter frozen, no wrap, inactive output.
    assign running  = cfg.en && (period_act != '0);
    assign wrap_set = running && (cnt == period_act - 1'b1);
    assign pwm      = (running && (cnt < pulse_act)) ^ cfg.pol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            period_act <= '0;
            pulse_act  <= '0;
        end else if (!cfg.en) begin
            cnt        <= '0;
            period_act <= period_sh;
            pulse_act  <= pulse_sh;
        end else if (wrap_set) begin
            cnt        <= '0;
            period_act <= period_sh;
            pulse_act  <= pulse_sh;
        end else if (running) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_pwm_mc.sv
// Multi-channel APB3 PWM slave: address decode, shadow/CTRL/STATUS registers, read mux.
// Latency: zero wait states; writes land on the edge ending the access phase.
// Backpressure: PREADY tied high; bad addresses answer PSLVERR with no side effects.
module apb_pwm_mc
    import apb_pwm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_CH       = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [DATA_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [N_CH-1:0]       PWM_O,
    output logic [N_CH-1:0]       IRQ_O
);

    localparam int CH_BITS = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(N_CH * 16);

    logic                  access;
    logic                  addr_err;
    logic                  wr_en;
    logic [CH_BITS-1:0]    ch_sel;
    logic [1:0]            reg_sel;
    chan_cfg_t             cfg_all [N_CH];
    chan_cfg_t             rd_cfg;
    logic [N_CH-1:0]       wrap_all;
    logic [N_CH-1:0]       wrap_set;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_wdata;

    assign access   = PSEL & PENABLE;
    assign addr_err = (PADDR[1:0] != 2'b00) || (PADDR >= ADDR_LIMIT);
    assign wr_en    = access & PWRITE & ~addr_err;
    assign ch_sel   = PADDR[4 +: CH_BITS];
    assign reg_sel  = PADDR[3:2];
    assign PREADY   = 1'b1;
    assign PSLVERR  = access & addr_err;
    assign unused_wdata = ^(PWDATA >> CNT_WIDTH);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        chan_cfg_t cfg_q;
        logic      wrap_q;
        logic      sel;
        logic      w1c;

        assign sel = wr_en && (ch_sel == CH_BITS'(c));
        assign w1c = sel && (reg_sel == REG_STATUS) && PWDATA[STATUS_WRAP];

        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                cfg_q  <= '0;
                wrap_q <= 1'b0;
            end else begin
                if (sel) begin
                    case (reg_sel)
                        REG_PERIOD: cfg_q.period <= CFG_W'(PWDATA[CNT_WIDTH-1:0]);
                        REG_PULSE:  cfg_q.pulse  <= CFG_W'(PWDATA[CNT_WIDTH-1:0]);
                        REG_CTRL: begin
                            cfg_q.en  <= PWDATA[CTRL_EN];
                            cfg_q.pol <= PWDATA[CTRL_POL];
                            cfg_q.ie  <= PWDATA[CTRL_IE];
                        end
                        default: ;
                    endcase
                end
                // A wrap on the same edge as a clear keeps the flag set.
                wrap_q <= wrap_set[c] | (wrap_q & ~w1c);
            end
        end

        assign cfg_all[c]  = cfg_q;
        assign wrap_all[c] = wrap_q;
        assign IRQ_O[c]    = wrap_q & cfg_q.ie;

        pwm_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk      (PCLK),
            .rst_n    (PRESETn),
            .cfg      (cfg_q),
            .wrap_set (wrap_set[c]),
            .pwm      (PWM_O[c])
        );
    end

    always_comb begin
        rd_cfg = cfg_all[ch_sel];
        rd_mux = '0;
        case (reg_sel)
            REG_PERIOD: rd_mux = DATA_WIDTH'(rd_cfg.period[CNT_WIDTH-1:0]);
            REG_PULSE:  rd_mux = DATA_WIDTH'(rd_cfg.pulse[CNT_WIDTH-1:0]);
            REG_CTRL:   rd_mux = DATA_WIDTH'({rd_cfg.ie, rd_cfg.pol, rd_cfg.en});
            default:    rd_mux = DATA_WIDTH'(wrap_all[ch_sel]);
        endcase
    end

    assign PRDATA = (access && !PWRITE && !addr_err) ? rd_mux : '0;

endmodule

// File: tb/tb_apb_pwm_mc.sv
// Directed bench for apb_pwm_mc: register access, PWM waveforms, reload, IRQ, errors, reset.
module tb_apb_pwm_mc;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  PWM_O;
    logic [3:0]  IRQ_O;

    int checks = 0;
    int errors = 0;

    apb_pwm_mc #(
        .DATA_WIDTH (32),
        .N_CH       (4),
        .CNT_WIDTH  (16)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .PWM_O   (PWM_O),
        .IRQ_O   (IRQ_O)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] ra(input int ch, input int r);
        return 32'(ch * 16 + r * 4);
    endfunction

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        data = PRDATA;
        err  = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        e;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        #3;
        checks++; if (PWM_O !== 4'h0) begin errors++; $display("FAIL reset_pwm got %h want 0", PWM_O); end
        checks++; if (IRQ_O !== 4'h0) begin errors++; $display("FAIL reset_irq got %h want 0", IRQ_O); end
        checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h want 0", PRDATA); end
        checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b want 0", PSLVERR); end
        checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL reset_pready got %b want 1", PREADY); end
        @(negedge PCLK); @(negedge PCLK);
        PRESETn = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            for (int r = 0; r < 4; r++) begin
                apb_read(ra(ch, r), d, e);
                checks++;
                if (d !== 32'h0 || e !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_read ch%0d reg%0d got data %h err %b want 0/0", ch, r, d, e);
                end
            end
        end
    endtask

    task automatic test_basic_pwm();
        logic [31:0] d;
        logic        e;
        apb_write(ra(0, 0), 32'd10, e);
        apb_write(ra(0, 1), 32'd3, e);
        apb_write(ra(0, 2), 32'h1, e);
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            checks++;
            if (PWM_O[0] !== ((i % 10) < 3)) begin
                errors++;
                $display("FAIL ch0_wave cycle %0d got %b want %b", i, PWM_O[0], (i % 10) < 3);
            end
        end
        checks++; if (IRQ_O[0] !== 1'b0) begin errors++; $display("FAIL ch0_irq_masked got %b want 0", IRQ_O[0]); end
        apb_read(ra(0, 3), d, e);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL ch0_wrap got %h want 1", d); end
        apb_write(ra(0, 2), 32'h0, e);
        apb_write(ra(0, 3), 32'h1, e);
        apb_read(ra(0, 3), d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ch0_wrap_clear got %h want 0", d); end
        apb_read(ra(0, 1), d, e);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL ch0_pulse_rd got %h want 3", d); end
    endtask

    task automatic test_reload();
        logic e;
        apb_write(ra(1, 0), 32'd8, e);
        apb_write(ra(1, 1), 32'd2, e);
        apb_write(ra(1, 2), 32'h1, e);
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int pw;
                    @(negedge PCLK);
                    pw = (i < 8) ? 2 : (i < 32) ? 6 : 1;
                    checks++;
                    if (PWM_O[1] !== ((i % 8) < pw)) begin
                        errors++;
                        $display("FAIL ch1_reload cycle %0d got %b want %b", i, PWM_O[1], (i % 8) < pw);
                    end
                end
            end
            begin
                logic e2;
                apb_write(ra(1, 1), 32'd6, e2);
                repeat (18) @(posedge PCLK);
                apb_write(ra(1, 1), 32'd1, e2);
            end
        join
        apb_write(ra(1, 2), 32'h0, e);
    endtask

    task automatic test_irq_pol();
        logic [31:0] d;
        logic        e;
        apb_write(ra(2, 0), 32'd4, e);
        apb_write(ra(2, 1), 32'd1, e);
        apb_write(ra(2, 2), 32'h7, e);
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            checks++;
            if (PWM_O[2] !== ((i % 4) != 0) || IRQ_O[2] !== (i >= 4)) begin
                errors++;
                $display("FAIL ch2_wave cycle %0d got pwm %b irq %b want %b %b",
                         i, PWM_O[2], IRQ_O[2], (i % 4) != 0, i >= 4);
            end
        end
        apb_write(ra(2, 3), 32'h1, e);
        checks++; if (IRQ_O[2] !== 1'b0) begin errors++; $display("FAIL ch2_w1c got %b want 0", IRQ_O[2]); end
        repeat (3) @(posedge PCLK);
        apb_write(ra(2, 3), 32'h1, e);
        checks++; if (IRQ_O[2] !== 1'b1) begin errors++; $display("FAIL ch2_w1c_on_wrap got %b want 1", IRQ_O[2]); end
        apb_read(ra(2, 2), d, e);
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL ch2_ctrl_rd got %h want 7", d); end
        apb_write(ra(2, 2), 32'h0, e);
        apb_write(ra(2, 3), 32'h1, e);
        checks++; if (IRQ_O[2] !== 1'b0 || PWM_O[2] !== 1'b0) begin
            errors++; $display("FAIL ch2_off got irq %b pwm %b want 0 0", IRQ_O[2], PWM_O[2]);
        end
    endtask

    task automatic test_slverr();
        logic [31:0] d;
        logic        e;
        apb_write(32'h42, 32'h55, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr42 got %b want 1", e); end
        apb_read(32'h42, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_rd42 got err %b data %h want 1/0", e, d); end
        apb_write(32'h40, 32'h77, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr40 got %b want 1", e); end
        apb_read(32'h40, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_rd40 got err %b data %h want 1/0", e, d); end
        apb_read(ra(0, 0), d, e);
        checks++; if (e !== 1'b0 || d !== 32'd10) begin errors++; $display("FAIL err_nochange got err %b data %h want 0/a", e, d); end
        apb_write(ra(0, 0), 32'hABCD_1234, e);
        apb_read(ra(0, 0), d, e);
        checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL trunc_period got %h want 1234", d); end
    endtask

    task automatic test_edges();
        logic [31:0] d;
        logic        e;
        apb_write(ra(3, 0), 32'd0, e);
        apb_write(ra(3, 1), 32'd3, e);
        apb_write(ra(3, 2), 32'h1, e);
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            checks++;
            if (PWM_O[3] !== 1'b0) begin errors++; $display("FAIL ch3_zero_period cycle %0d got %b want 0", i, PWM_O[3]); end
        end
        apb_read(ra(3, 3), d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ch3_zero_wrap got %h want 0", d); end
        apb_write(ra(3, 2), 32'h0, e);
        apb_write(ra(3, 0), 32'd5, e);
        apb_write(ra(3, 1), 32'd5, e);
        apb_write(ra(3, 2), 32'h1, e);
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            checks++;
            if (PWM_O[3] !== 1'b1) begin errors++; $display("FAIL ch3_full_pulse cycle %0d got %b want 1", i, PWM_O[3]); end
        end
        apb_write(ra(2, 2), 32'h2, e);
        checks++; if (PWM_O[2] !== 1'b1) begin errors++; $display("FAIL ch2_pol_idle got %b want 1", PWM_O[2]); end
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        checks++; if (PWM_O !== 4'h0 || IRQ_O !== 4'h0) begin
            errors++; $display("FAIL async_reset got pwm %h irq %h want 0 0", PWM_O, IRQ_O);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        apb_read(ra(3, 0), d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ch3_period got %h want 0", d); end
        apb_read(ra(2, 2), d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ch2_ctrl got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_basic_pwm();
        test_reload();
        test_irq_pol();
        test_slverr();
        test_edges();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_pwm_mc.md
# apb_pwm_mc

Multi-channel APB3 PWM peripheral: N_CH independent PWM generators, each with its own free-running counter, double-buffered PERIOD/PULSE registers, programmable output polarity and a sticky period-wrap interrupt. Sits on the APB peripheral bus as a single slave. Software writes shadow registers at any time; active values reload only at period boundaries, so PWM_O never glitches mid-period.

## Interface
- DATA_WIDTH, 32: APB address/data width.
- N_CH, 4: number of channels, power of two, 1..16.
- CNT_WIDTH, 16: counter and PERIOD/PULSE width (≤ DATA_WIDTH).
- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- PADDR  in  DATA_WIDTH  byte address, word aligned.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  always 1 (zero wait states).
- PSLVERR  out  1  error response.
- PWM_O  out  N_CH  per-channel PWM outputs.
- IRQ_O  out  N_CH  per-channel level interrupts.

## Operation
- Address map: channel c = PADDR[4+log2(N_CH)-1:4], register = PADDR[3:2]. Offsets: 0x0 PERIOD (shadow), 0x4 PULSE (shadow), 0x8 CTRL (bit0 EN, bit1 POL, bit2 IE), 0xC STATUS (bit0 WRAP, write-1-to-clear).
- PSLVERR = 1 in access phase if PADDR[1:0] ≠ 0 or PADDR ≥ N_CH·16; erroneous writes have no effect, erroneous reads return 0.
- Reads: PRDATA = zero-extended register value while PSEL&PENABLE&~PWRITE, else 0. PERIOD/PULSE read back the shadow, not the active value.
- Writes take effect at the PCLK edge ending the access phase. Upper bits beyond CNT_WIDTH (or beyond the CTRL/STATUS fields) are dropped.
- Per channel, when EN=0: cnt = 0; active PERIOD/PULSE copy their shadows every cycle; WRAP is not set.
- When EN=1: cnt increments each cycle; when cnt == period_act−1, cnt → 0, active ← shadow, WRAP ← 1.
- period_act = 0: cnt held at 0, output inactive, no WRAP.
- PWM_O[c] = ((EN & period_act≠0 & cnt < pulse_act) ^ POL), combinational from registered state. pulse_act ≥ period_act gives a constant active level; pulse_act = 0 gives a constant inactive level.
- IRQ_O[c] = WRAP & IE.

## Timing
- Reset: all shadow/active registers, cnt, CTRL and STATUS = 0; PWM_O = 0; IRQ_O = 0; PRDATA = 0; PSLVERR = 0.
- The edge writing EN 0→1 leaves cnt = 0 with active = current shadow. The first active cycle follows immediately and the period is exactly period_act cycles.
- Shadow write on the same edge as a wrap: active loads the pre-write shadow; the new value applies from the next wrap.
- STATUS W1C on the same edge as a wrap set: set wins, WRAP stays 1.
- EN 1→0: cnt = 0 on the next cycle; output goes to the POL level immediately after that edge.
- Reset mid-period: all state clears asynchronously; the output drops to 0 regardless of POL.

## Structure
- Package apb_pwm_pkg: register offset localparams, CTRL bit indices, channel register struct (period, pulse, en, pol, ie).
- Sub-module pwm_channel (one per channel, generate loop): counter, active registers, reload, WRAP logic, output. The top level holds the APB decode, shadow/CTRL/STATUS registers and the read mux.

## Test plan
- Reset then read all registers of all channels -> every read returns 0, PWM_O = 0, PSLVERR = 0.
- Ch0 PERIOD=10, PULSE=3, CTRL=0x1 -> PWM_O[0] high 3 cycles, low 7, repeating; WRAP set every 10 cycles.
- Ch1 running PERIOD=8/PULSE=2, write PULSE=6 mid-period -> current period keeps 2 high cycles, the next period has 6; write coinciding with the wrap edge takes effect one period later.
- Ch2 CTRL=0x7 (EN, POL, IE), PERIOD=4, PULSE=1 -> PWM_O low 1 / high 3; IRQ_O[2] rises at the first wrap; W1C STATUS clears it; W1C issued on a wrap edge leaves IRQ_O = 1.
- Access PADDR=0x42 and, with N_CH=4, PADDR=0x40 -> PSLVERR = 1, no register changes, PRDATA = 0.
- Edge cases on ch3: PERIOD=0 -> output inactive, no WRAP; PULSE=PERIOD=5 -> constant high; assert PRESETn low mid-period -> all outputs 0 within the same cycle.
